pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that replaces the fixed 16-bit program counter and its branch/jump selection in the CPU datapath. It adds a hardware call/return stack, a stall input, a halt/resume state machine and sticky fault detection. It sits between the control unit, which supplies flow-control strobes, and the instruction memory, which consumes pc.

---
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch/jump/call/ret selection, hardware return stack,
// stall, halt/resume and sticky stack-fault detection.
module pc_sequencer #(
    parameter int                   ADDR_W      = 16,
    parameter int                   IMM_W       = 16,
    parameter int                   STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]    RESET_ADDR  = '0,
    localparam int                  LVL_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              hlt,
    input  logic              resume,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_offset,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              halted,
    output logic              fault,
    output logic [LVL_W-1:0]  stack_level,
    output logic              stack_overflow,
    output logic              stack_underflow,
    output logic              redirect
);
    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    localparam int EXT_W = (IMM_W > ADDR_W) ? IMM_W : ADDR_W;

    state_t                               state_q, state_d;
    logic [ADDR_W-1:0]                    pc_d;
    logic [LVL_W-1:0]                     level_d;
    logic                                 ovf_d, unf_d, redir_d, push, pop;
    logic [EXT_W-1:0]                     off_ext;
    logic [ADDR_W-1:0]                    branch_tgt;
    logic [STACK_DEPTH-1:0][ADDR_W-1:0]   stk, stk_push, stk_pop;

    assign pc_plus1   = pc + ADDR_W'(1);
    assign off_ext    = EXT_W'($signed(branch_offset));
    assign branch_tgt = pc_plus1 + off_ext[ADDR_W-1:0];
    assign halted     = (state_q == HALTED);
    assign fault      = (state_q == FAULT);

    // Shift-register stack: entry 0 is always the top, so no level-indexed reads are needed.
    for (genvar i = 0; i < STACK_DEPTH; i++) begin : g_stk
        if (i == 0) begin : g_top
            assign stk_push[i] = pc_plus1;
        end else begin : g_mid
            assign stk_push[i] = stk[i-1];
        end
        if (i == STACK_DEPTH - 1) begin : g_bot
            assign stk_pop[i] = stk[i];
        end else begin : g_up
            assign stk_pop[i] = stk[i+1];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        level_d = stack_level;
        ovf_d   = stack_overflow;
        unf_d   = stack_underflow;
        redir_d = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            RUN: begin
                if (hlt) begin
                    state_d = HALTED;
                end else if (ret) begin
                    if (stack_level != '0) begin
                        pc_d    = stk[0];
                        level_d = stack_level - LVL_W'(1);
                        pop     = 1'b1;
                        redir_d = 1'b1;
                    end else begin
                        unf_d   = 1'b1;
                        state_d = FAULT;
                    end
                end else if (call) begin
                    if (stack_level < LVL_W'(STACK_DEPTH)) begin
                        pc_d    = jump_target;
                        level_d = stack_level + LVL_W'(1);
                        push    = 1'b1;
                        redir_d = 1'b1;
                    end else begin
                        ovf_d   = 1'b1;
                        state_d = FAULT;
                    end
                end else if (jump) begin
                    pc_d    = jump_target;
                    redir_d = 1'b1;
                end else if (branch_taken) begin
                    pc_d    = branch_tgt;
                    redir_d = 1'b1;
                end else begin
                    pc_d = pc_plus1;
                end
            end
            HALTED: begin
                // resume wins over a simultaneous hlt
                if (resume) begin
                    pc_d    = pc_plus1;
                    state_d = RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= RUN;
            pc              <= RESET_ADDR;
            stack_level     <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
            redirect        <= 1'b0;
        end else if (advance) begin
            state_q         <= state_d;
            pc              <= pc_d;
            stack_level     <= level_d;
            stack_overflow  <= ovf_d;
            stack_underflow <= unf_d;
            redirect        <= redir_d;
        end else begin
            redirect        <= 1'b0;
        end
    end

    // Stack contents are don't-care after reset; only stack_level qualifies them.
    always_ff @(posedge clock) begin
        if (advance && push)
            stk <= stk_push;
        else if (advance && pop)
            stk <= stk_pop;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (STACK_DEPTH=2) with hand-computed expectations.
module tb_pc_sequencer;
    logic        clock = 1'b0;
    logic        reset, advance, hlt, resume, branch_taken, jump, call, ret;
    logic [15:0] branch_offset, jump_target, pc, pc_plus1;
    logic        halted, fault, stack_overflow, stack_underflow, redirect;
    logic [1:0]  stack_level;
    int          checks = 0;
    int          errors = 0;

    pc_sequencer #(.ADDR_W(16), .IMM_W(16), .STACK_DEPTH(2), .RESET_ADDR(16'h0000)) dut (
        .clock(clock), .reset(reset), .advance(advance), .hlt(hlt), .resume(resume),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .call(call), .ret(ret), .jump_target(jump_target), .pc(pc), .pc_plus1(pc_plus1),
        .halted(halted), .fault(fault), .stack_level(stack_level),
        .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
        .redirect(redirect)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        hlt = 0; resume = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
        branch_offset = 16'h0; jump_target = 16'h0;
    endtask

    task automatic do_jump(input logic [15:0] t);
        clr(); jump = 1; jump_target = t; step(); clr();
    endtask

    initial begin
        clr();
        advance = 0;
        reset = 1;
        repeat (2) step();
        reset = 0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_level", stack_level, 0);
        chk("rst_ovf", stack_overflow, 0);
        chk("rst_unf", stack_underflow, 0);
        chk("rst_redirect", redirect, 0);
        chk("rst_pc_plus1", pc_plus1, 1);

        // sequential count, async reset mid-count
        advance = 1;
        repeat (5) step();
        chk("seq_pc5", pc, 5);
        #2 reset = 1;
        #1 chk("async_rst_pc", pc, 0);
        @(negedge clock);
        reset = 0;
        repeat (4) step();
        chk("seq_pc4", pc, 4);
        advance = 0;
        repeat (3) step();
        chk("stall_pc", pc, 4);
        chk("stall_redirect", redirect, 0);

        // redirect is forced low by a stall edge
        advance = 1;
        do_jump(16'd10);
        chk("jump_pc", pc, 10);
        chk("jump_redirect", redirect, 1);
        branch_taken = 1; branch_offset = 16'hFFFD;
        advance = 0; step();
        chk("stall_clears_redirect", redirect, 0);
        chk("stall_branch_pc", pc, 10);
        advance = 1; step(); clr();
        chk("branch_neg_pc", pc, 8);
        chk("branch_redirect", redirect, 1);
        step();
        chk("after_branch_pc", pc, 9);
        chk("redirect_pulse_end", redirect, 0);

        // wraps
        do_jump(16'hFFFF);
        step();
        chk("seq_wrap", pc, 16'h0000);
        do_jump(16'hFFFE);
        branch_taken = 1; branch_offset = 16'd5; step(); clr();
        chk("branch_wrap", pc, 16'h0004);

        // nested call/ret
        do_jump(16'd3);
        call = 1; jump_target = 16'h40; step(); clr();
        chk("call1_pc", pc, 16'h40);
        chk("call1_level", stack_level, 1);
        repeat (2) step();
        call = 1; jump_target = 16'h80; step(); clr();
        chk("call2_pc", pc, 16'h80);
        chk("call2_level", stack_level, 2);
        ret = 1; step();
        chk("ret1_pc", pc, 16'h43);
        chk("ret1_level", stack_level, 1);
        step(); clr();
        chk("ret2_pc", pc, 16'h4);
        chk("ret2_level", stack_level, 0);

        // priority
        jump = 1; jump_target = 16'h100; branch_taken = 1; branch_offset = 16'd5; step(); clr();
        chk("prio_jump_over_branch", pc, 16'h100);
        call = 1; jump = 1; jump_target = 16'h200; step(); clr();
        chk("prio_call_pc", pc, 16'h200);
        chk("prio_call_level", stack_level, 1);
        ret = 1; jump = 1; jump_target = 16'h300; step(); clr();
        chk("prio_ret_over_jump", pc, 16'h101);
        chk("prio_ret_level", stack_level, 0);

        // halt/resume
        do_jump(16'd7);
        hlt = 1; ret = 1; step(); clr();
        chk("hlt_pc", pc, 7);
        chk("hlt_halted", halted, 1);
        chk("hlt_redirect", redirect, 0);
        chk("hlt_beats_ret", stack_underflow, 0);
        jump = 1; jump_target = 16'h55; step(); clr();
        chk("halted_jump_ignored", pc, 7);
        resume = 1; advance = 0; step();
        chk("halted_stall_resume", halted, 1);
        advance = 1; step(); clr();
        chk("resume_pc", pc, 8);
        chk("resume_halted", halted, 0);
        do_jump(16'd7);
        hlt = 1; step();
        resume = 1; step(); clr();
        chk("hlt_resume_pc", pc, 8);
        chk("hlt_resume_halted", halted, 0);

        // overflow with depth 2
        call = 1; jump_target = 16'h10; step();
        jump_target = 16'h20; step();
        jump_target = 16'h30; step(); clr();
        chk("ovf_pc", pc, 16'h20);
        chk("ovf_flag", stack_overflow, 1);
        chk("ovf_fault", fault, 1);
        chk("ovf_level", stack_level, 2);
        chk("ovf_redirect", redirect, 0);
        jump = 1; jump_target = 16'h99; step(); clr();
        call = 1; resume = 1; ret = 1; step(); clr();
        chk("fault_hold_pc", pc, 16'h20);
        chk("fault_hold_level", stack_level, 2);
        chk("fault_hold", fault, 1);
        #2 reset = 1;
        #1;
        chk("ovf_rst_pc", pc, 0);
        chk("ovf_rst_flag", stack_overflow, 0);
        chk("ovf_rst_fault", fault, 0);
        chk("ovf_rst_level", stack_level, 0);
        @(negedge clock);
        reset = 0;

        // underflow
        ret = 1; step(); clr();
        chk("unf_flag", stack_underflow, 1);
        chk("unf_fault", fault, 1);
        chk("unf_pc", pc, 0);
        chk("unf_ovf_clear", stack_overflow, 0);
        step();
        chk("unf_sticky", stack_underflow, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
